// File: rtl/serial_subtractor_pkg.sv
// Shared arithmetic definitions: FSM state encoding and the default operand width
// used by the serial subtractor and its interface.
package arith_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/response bundle between a requester (master) and the serial subtractor (slave).
interface serial_subtractor_if
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow
  );

endinterface

// File: rtl/serial_subtractor_fsub.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b LSB-first through one full-subtractor
// cell and a borrow flop, publishing diff/borrow with a one-cycle done pulse.
//
//   state   | meaning
//   --------+---------------------------------------------------
//   ST_IDLE | waiting for start; operands captured on accept
//   ST_RUN  | one bit-step per clock, WIDTH steps total
//   ST_DONE | done pulse cycle; start ignored, returns to idle
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] res_q;
  logic             brw_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;

  logic             d_bit;
  logic             bout_bit;
  logic [WIDTH-1:0] res_d;
  logic             last_step;

  full_subtractor u_fsub (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .bin  (brw_q),
    .d    (d_bit),
    .bout (bout_bit)
  );

  // Result fills from the top so the first (LSB) difference bit lands at bit 0 after WIDTH shifts.
  assign res_d     = {d_bit, res_q[WIDTH-1:1]};
  assign last_step = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      brw_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            sa_q    <= bus.a;
            sb_q    <= bus.b;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          res_q <= res_d;
          brw_q <= bout_bit;
          cnt_q <= cnt_q + CW'(1);
          if (last_step) begin
            diff_q   <= res_d;
            borrow_q <= bout_bit;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;

endmodule
